vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator plus built-in test-pattern source; successor to the fixed SXGA generator.
//  Any mode via parameters, sync polarity select, pixel clock-enable, pixel coordinates, frame/line strobes, 4 selectable patterns.
//  Sits between the PLL pixel clock and the board VGA DAC pins; x/y/de/sof also feed future frame-buffer readers.
// PARAMETERS
//  H_ACTIVE 1280  visible pixels/line      | H_FP 48  | H_SYNC 112 | H_BP 248   (H_TOTAL=1688)
//  V_ACTIVE 1024  visible lines/frame      | V_FP 1   | V_SYNC 3   | V_BP 38    (V_TOTAL=1066)
//  HS_POL   1     hs active level (1=high) | VS_POL 1 vs active level
//  CW       4     bits per colour component
//  Constraints: H_ACTIVE multiple of 8; all porch/sync values >=1. XW=clog2(H_TOTAL), YW=clog2(V_TOTAL).
// PORTS
//  clk        in   1      pixel clock (108 MHz for default mode)
//  rst        in   1      asynchronous reset, active high
//  ce         in   1      pixel enable; counters/outputs advance only when 1
//  pat_sel    in   2      0 colour bars, 1 grid, 2 gradient, 3 solid
//  solid_rgb  in   3*CW   {r,g,b} used by pattern 3
//  hs         out  1      horizontal sync, polarity HS_POL
//  vs         out  1      vertical sync, polarity VS_POL
//  de         out  1      active-video flag
//  x          out  XW     pixel column of current output (valid when de)
//  y          out  YW     pixel row of current output (valid when de)
//  sof        out  1      start-of-frame strobe, with pixel (0,0)
//  eol        out  1      end-of-active-line strobe, with pixel (H_ACTIVE-1, y<V_ACTIVE)
//  r,g,b      out  CW     pixel colour; forced 0 when de=0
// BEHAVIOUR
//  Reset (async): hcnt=vcnt=0, hs=~HS_POL, vs=~VS_POL, de=0, x=y=0, sof=eol=0, r=g=b=0, latched pattern=0, bar counters=0.
//  Counters: on clk with ce=1, hcnt++ ; hcnt==H_TOTAL-1 -> hcnt=0, vcnt++ ; vcnt==V_TOTAL-1 at line wrap -> vcnt=0.
//  ce=0: counters, hs, vs, de, x, y, rgb hold; sof/eol forced 0 (strobes never longer than one clk).
//  Latency: all outputs registered, 1 clk after the ce cycle that sampled (hcnt,vcnt).
//  Line order: active [0,H_ACTIVE), FP, sync, BP. hs active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//  vs active for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), changes only with hcnt==0.
//  de = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE); x=hcnt, y=vcnt when de; x/y hold last value otherwise.
//  pat_sel and solid_rgb are latched only on the ce cycle with hcnt==0,vcnt==0 -> no mid-frame pattern change.
//  Colour bars: 8 bars of H_ACTIVE/8 pixels, index i via bar pixel counter + 3-bit bar counter (no divider), both
//   cleared at hcnt==0. r=~i[1], g=~i[2], b=~i[0], each replicated to CW bits:
//   white,yellow,cyan,green,magenta,red,blue,black.
//  Grid: all-ones where x[4:0]==0 or y[4:0]==0 or x==H_ACTIVE-1 or y==V_ACTIVE-1, else 0.
//  Gradient: r=x[CW+3:4], g=y[CW+3:4], b=r^g (wraps naturally modulo 2^CW).
//  Solid: {r,g,b}=latched solid_rgb.
//  Blanking: when de=0, r=g=b=0 regardless of pattern.
// TESTING (bench params H 16/2/3/3, V 8/1/2/1, HS_POL=0, VS_POL=1, CW=4; H_TOTAL=24, V_TOTAL=12)
//  Reset mid-line (hcnt=10) with ce=1 -> next clk hs=1, vs=0, de=0, rgb=0; after release first sof at 1st clk, x=y=0.
//  ce=1 for 2 frames -> sof period 288 clk, de high 16 of every 24 clk on lines 0..7, hs low hcnt 18..20, vs high lines 9..10.
//  ce toggling 1/0 -> sof period 576 clk, outputs frozen while ce=0, sof/eol each exactly 1 clk wide.
//  pat_sel=0 -> line 0 rgb pairs FFF,FF0,0FF,0F0,F0F,F00,00F,000 (2 px each); eol at x=15.
//  pat_sel 0->3 at (5,3), solid_rgb=0x5A3 -> bars continue to end of frame; next frame all active pixels 5,A,3.
//  pat_sel=1 -> pixel (0,y) and (x,0) =FFF, (15,y)=FFF, (1,1)=000; blanking intervals all 000.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a built-in test-pattern source.
//
// Ports:
//   clk        pixel clock
//   rst        asynchronous reset, active high
//   ce         pixel enable; counters and outputs advance only when 1
//   pat_sel    pattern select: 0 colour bars, 1 grid, 2 gradient, 3 solid
//   solid_rgb  {r,g,b} colour used by the solid pattern
//   hs, vs     horizontal / vertical sync at polarity HS_POL / VS_POL
//   de         active-video flag
//   x, y       pixel column / row of the current output (valid when de)
//   sof        start-of-frame strobe, coincident with pixel (0,0)
//   eol        end-of-active-line strobe, coincident with pixel (H_ACTIVE-1, y)
//   r, g, b    pixel colour, zero during blanking
//
// All outputs are registered: they reflect the (hcnt, vcnt) sampled on the
// previous ce cycle.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned CW       = 4,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [1:0]      pat_sel,
    input  logic [3*CW-1:0] solid_rgb,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic            sof,
    output logic            eol,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0]  H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0]  V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0]  H_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0]  V_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0]  H_ALAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  V_ALAST  = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0]  HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]  HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0]  VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]  VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

    logic [XW-1:0]    hcnt_q, hcnt_d;
    logic [YW-1:0]    vcnt_q, vcnt_d;
    logic [BPW-1:0]   bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [1:0]       pat_q, pat_eff;
    logic [3*CW-1:0]  solid_q, solid_eff;

    logic             hs_q, vs_q, de_q, sof_q, eol_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [3*CW-1:0]  rgb_q, rgb_d;

    logic             h_last, origin, active, hs_act, vs_act, eol_hit, grid_on;
    logic [CW-1:0]    grad_r, grad_g;

    always_comb begin
        h_last  = (hcnt_q == H_LAST);
        origin  = (hcnt_q == '0) && (vcnt_q == '0);
        active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_act  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        vs_act  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        eol_hit = (hcnt_q == H_ALAST) && (vcnt_q < V_ACT);

        hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_last) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end

        // Bar counters track the bar of the pixel at hcnt_q; both are zero
        // whenever hcnt_q is zero, so no divider is needed.
        bar_px_d  = bar_px_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (h_last) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end

        // At the origin the fresh selection already applies to pixel (0,0).
        pat_eff   = origin ? pat_sel : pat_q;
        solid_eff = origin ? solid_rgb : solid_q;

        grid_on = ((32'(hcnt_q) & 32'd31) == 32'd0) || ((32'(vcnt_q) & 32'd31) == 32'd0)
                  || (hcnt_q == H_ALAST) || (vcnt_q == V_ALAST);
        grad_r  = CW'(32'(hcnt_q) >> 4);
        grad_g  = CW'(32'(vcnt_q) >> 4);

        unique case (pat_eff)
            2'd0: rgb_d = {{CW{~bar_idx_q[1]}}, {CW{~bar_idx_q[2]}}, {CW{~bar_idx_q[0]}}};
            2'd1: rgb_d = {3*CW{grid_on}};
            2'd2: rgb_d = {grad_r, grad_g, grad_r ^ grad_g};
            default: rgb_d = solid_eff;
        endcase
        if (!active) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            sof_q <= ce & origin;
            eol_q <= ce & eol_hit;
            if (ce) begin
                hcnt_q    <= hcnt_d;
                vcnt_q    <= vcnt_d;
                bar_px_q  <= bar_px_d;
                bar_idx_q <= bar_idx_d;
                pat_q     <= pat_eff;
                solid_q   <= solid_eff;
                hs_q      <= hs_act ? HS_POL : ~HS_POL;
                vs_q      <= vs_act ? VS_POL : ~VS_POL;
                de_q      <= active;
                rgb_q     <= rgb_d;
                if (active) begin
                    x_q <= hcnt_q;
                    y_q <= vcnt_q;
                end
            end
        end
    end

    assign hs  = hs_q;
    assign vs  = vs_q;
    assign de  = de_q;
    assign x   = x_q;
    assign y   = y_q;
    assign sof = sof_q;
    assign eol = eol_q;
    assign r   = rgb_q[3*CW-1:2*CW];
    assign g   = rgb_q[2*CW-1:CW];
    assign b   = rgb_q[CW-1:0];

endmodule
